// File: rtl/data_memory_unit_pkg.sv
// Shared constants for the data memory unit: bus widths, MMIO window layout,
// STATUS bit positions and the address decoder.
package data_memory_unit_pkg;

    localparam int ADDRESS_SIZE = 16;
    localparam int DATA_SIZE    = 16;

    localparam int MMIO_WINDOW = 16;
    localparam logic [ADDRESS_SIZE-1:0] MMIO_BASE = ADDRESS_SIZE'(2**ADDRESS_SIZE - MMIO_WINDOW);

    localparam logic [3:0] MMIO_CYCLE   = 4'd0;
    localparam logic [3:0] MMIO_OUT     = 4'd1;
    localparam logic [3:0] MMIO_STATUS  = 4'd2;
    localparam logic [3:0] MMIO_SCRATCH = 4'd3;

    localparam int STATUS_FULL    = 0;
    localparam int STATUS_EMPTY   = 1;
    localparam int STATUS_DROPPED = 2;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_NONE
    } region_e;

    function automatic region_e decode_region(input logic [ADDRESS_SIZE-1:0] addr,
                                              input int                      ram_depth);
        if (32'(addr) < ram_depth)
            return REGION_RAM;
        else if (addr >= MMIO_BASE)
            return REGION_MMIO;
        else
            return REGION_NONE;
    endfunction

endpackage

// File: rtl/data_memory_unit_mmio_fifo.sv
// Output FIFO behind the OUT register. Head word and valid are registered so
// the stream side sees flop outputs only; overflow pulses when a push is lost.
module mmio_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_SIZE  = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic [DATA_SIZE-1:0]        push_data,
    input  logic                        pop,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        head_valid,
    output logic [DATA_SIZE-1:0]        head,
    output logic                        overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr, rd_ptr_next;
    logic [PW:0]          count_next;
    logic [DATA_SIZE-1:0] head_next;
    logic                 do_push, do_pop;

    assign full        = (count == (PW+1)'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign do_pop      = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_push     = push && (!full || do_pop);
    assign overflow    = push && full && !do_pop;
    assign rd_ptr_next = rd_ptr + PW'(do_pop);
    assign count_next  = count + (PW+1)'(do_push) - (PW+1)'(do_pop);

    // The slot becoming head may be the one written this cycle (FIFO drained to
    // empty, or was empty); bypass the push data in that case.
    assign head_next = (do_push && wr_ptr == rd_ptr_next) ? push_data : mem[rd_ptr_next];

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head       <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            head_valid <= (count_next != '0);
            if (count_next != '0)
                head <= head_next;
        end
    end

endmodule

// File: rtl/data_memory_unit.sv
// Data-side responder: word RAM plus an MMIO window (cycle counter, status,
// scratch, output FIFO push port). Loads are combinational, stores commit at the edge.
module data_memory_unit
    import data_memory_unit_pkg::*;
#(
    parameter int RAM_DEPTH  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDRESS_SIZE-1:0] address,
    input  logic [DATA_SIZE-1:0]    data_out,
    output logic [DATA_SIZE-1:0]    data_in,
    output logic                    out_valid,
    output logic [DATA_SIZE-1:0]    out_data,
    input  logic                    out_ready
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_SIZE-1:0] ram [RAM_DEPTH];
    logic [DATA_SIZE-1:0] cycle_count;
    logic [DATA_SIZE-1:0] scratch;
    logic                 dropped;

    region_e     region;
    logic [3:0]  offset;
    logic        mmio_wr;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_overflow;
    logic [CW-1:0] fifo_count;

    assign region    = decode_region(address, RAM_DEPTH);
    assign offset    = address[3:0];
    assign mmio_wr   = write && (region == REGION_MMIO);
    assign fifo_push = mmio_wr && (offset == MMIO_OUT);
    assign fifo_pop  = out_valid && out_ready;

    mmio_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_SIZE  (DATA_SIZE)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (fifo_push),
        .push_data  (data_out),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .head_valid (out_valid),
        .head       (out_data),
        .overflow   (fifo_overflow)
    );

    // RAM is deliberately outside the reset domain so contents survive a reset.
    always_ff @(posedge clock) begin
        if (write && region == REGION_RAM)
            ram[address[RAM_AW-1:0]] <= data_out;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            scratch     <= '0;
            dropped     <= 1'b0;
        end else begin
            cycle_count <= cycle_count + DATA_SIZE'(1);
            if (mmio_wr && offset == MMIO_SCRATCH)
                scratch <= data_out;
            // A lost push in the same cycle as a clear keeps the flag set.
            if (fifo_overflow)
                dropped <= 1'b1;
            else if (mmio_wr && offset == MMIO_STATUS && data_out[STATUS_DROPPED])
                dropped <= 1'b0;
        end
    end

    always_comb begin
        data_in = '0;
        if (read) begin
            case (region)
                REGION_RAM: data_in = ram[address[RAM_AW-1:0]];
                REGION_MMIO: begin
                    case (offset)
                        MMIO_CYCLE:   data_in = cycle_count;
                        MMIO_OUT:     data_in = DATA_SIZE'(fifo_count);
                        MMIO_STATUS: begin
                            data_in[STATUS_FULL]    = fifo_full;
                            data_in[STATUS_EMPTY]   = fifo_empty;
                            data_in[STATUS_DROPPED] = dropped;
                        end
                        MMIO_SCRATCH: data_in = scratch;
                        default:      data_in = '0;
                    endcase
                end
                default: data_in = '0;
            endcase
        end
    end

endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Data-side responder for the core's memory port: it answers the core's `read`/`write`/`address`/`data_out` requests and returns `data_in`. Contents:
- a word-addressed RAM;
- a memory-mapped I/O window at the top of the address space, holding a free-running cycle counter, a status register, a scratch register and a push port into an output FIFO.

The FIFO drains to an external valid/ready stream. The block sits beside the core at top level, opposite the core's load/store path.

## Interface
- `RAM_DEPTH`, 256, number of RAM words; power of two, ≤ 2^`ADDRESS_SIZE` − 16.
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥ 2.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `read`  in  1  load request from core (active 1).
- `write`  in  1  store request from core (active 1).
- `address`  in  `ADDRESS_SIZE`  word address.
- `data_out`  in  `DATA_SIZE`  store data from core.
- `data_in`  out  `DATA_SIZE`  load data to core.
- `out_valid`  out  1  FIFO head valid.
- `out_data`  out  `DATA_SIZE`  FIFO head word.
- `out_ready`  in  1  sink accepts head this cycle.

## Operation
- Decode:
  - RAM when `address` < `RAM_DEPTH`.
  - MMIO when `address` ≥ 2^`ADDRESS_SIZE` − 16; offset = `address`[3:0].
  - Everything else is unmapped: reads return 0, writes are ignored.
- MMIO offsets:
  - 0 CYCLE (R): counter value. Writes ignored.
  - 1 OUT: write pushes `data_out[DATA_SIZE-1:0]`; read returns FIFO occupancy, zero-extended.
  - 2 STATUS: read bit0 = full, bit1 = empty, bit2 = dropped (sticky), other bits 0. Writing 1 to bit2 clears dropped; other bits are ignored.
  - 3 SCRATCH (RW).
  - 4–15: read 0, write ignored.
- Reads are combinational. `data_in` = 0 whenever `read` = 0.
- `read` and `write` together: the read returns the pre-write value, and the write commits at the edge.
- Cycle counter: `DATA_SIZE` bits, +1 every cycle, wraps all-ones → 0.
- FIFO:
  - Push when full with no pop in the same cycle: data is discarded and dropped is set.
  - Push and pop in the same cycle while full: both take effect and occupancy is unchanged.
  - Push and pop in the same cycle while empty: the push is stored. The pop is void because `out_valid` = 0.
  - Occupancy counter width is log2(`FIFO_DEPTH`)+1. Read/write pointers wrap modulo `FIFO_DEPTH`.
- STATUS write clearing dropped in the same cycle as an overflowing push: set wins.

## Timing
- Load latency 0: `data_in` is valid in the same cycle as `read`/`address`.
- Stores, MMIO side effects and FIFO pushes commit on the rising edge of the request cycle. A read of the same location in the next cycle sees the new value.
- Stream handshake:
  - A transfer occurs on an edge where `out_valid` && `out_ready`.
  - `out_data` is the registered FIFO head and is stable while `out_valid` = 1 and not accepted.
  - `out_valid` is registered: it rises one cycle after a push into an empty FIFO.
- Reset values:
  - Outputs: `out_valid` 0, `out_data` 0, `data_in` 0 (combinational, with `read` low).
  - State: counter 0, SCRATCH 0, FIFO empty, dropped 0.
- RAM contents are not reset. They are unaffected by reset assertion mid-operation. Undefined after power-up until written.
- Reset asserted mid-transfer aborts the transfer: the FIFO is emptied immediately and `out_valid` drops asynchronously.

## Structure
- Add MMIO offsets, the STATUS bit positions and the MMIO window size (16) to `architecture.vh` as constants.
- Sub-module `mmio_fifo` (parameters `FIFO_DEPTH`, `DATA_SIZE`). Ports: push/pop/full/empty/count/head, plus an overflow pulse that feeds the sticky dropped flag.
- RAM, decode, counter and registers stay in `data_memory_unit`.

## Test plan
- Write 0xA5 to RAM address 3, then read address 3 the next cycle → `data_in` = 0xA5. The same-cycle read before the edge returns the old value.
- Reset released; read CYCLE at cycles 1 and 6 after release → values differ by 5. Force the counter near all-ones and observe the wrap to 0.
- Push 5 words into a 4-deep FIFO with `out_ready` = 0 → STATUS = full|dropped (0b101), OUT read = 4. Raise `out_ready` → the first 4 words emerge in order and the 5th is absent.
- With the FIFO full, push and pop in the same cycle → occupancy stays 4, dropped stays 0, and the new word appears last.
- Write STATUS = 0b100 → dropped cleared. Read unmapped address `RAM_DEPTH` → 0. Write there, then read RAM 0 → unchanged.
- Assert `reset` with 2 entries queued and `out_valid` high → `out_valid` drops immediately, OUT read = 0, SCRATCH = 0, and RAM data is retained.
